perceptron_train_controller: RTL and testbench

Sequencer that owns the write ports of the perceptron weight/bias table. After reset it sweeps every table entry to zero. It then accepts resolved-branch training requests over a valid/ready handshake and decides whether training is required. When it is, it serialises the saturating weight updates through the single table write port, one table per cycle, with the bias update issued in the same cycle as table 0.

---
 rtl/perceptron_train_controller_pkg.sv | 30 +++
 rtl/perceptron_weight_updater.sv | 27 ++
 rtl/perceptron_train_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_perceptron_train_controller.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_train_controller_pkg.sv
// Shared geometry, training constants and state encoding for the perceptron
// training sequencer.
package perceptron_train_controller_pkg;

    localparam int NUM_TABLES                   = 4;
    localparam int PERCEPTRON_TABLE_NUM_ENTRIES = 256;
    localparam int PERCEPTRON_NUM_WEIGHTS       = 8;
    localparam int PERCEPTRON_WEIGHT_WIDTH      = 8;
    localparam int BIAS_TABLE_NUM_ENTRIES       = 1024;
    localparam int BIAS_WEIGHT_WIDTH            = 8;

    localparam int HISTORY_LENGTH  = NUM_TABLES * PERCEPTRON_NUM_WEIGHTS;
    // floor(1.93*h + 14) using integer arithmetic
    localparam int TRAIN_THRESHOLD = (193 * HISTORY_LENGTH + 1400) / 100;
    localparam int SUM_WIDTH       = 16;

    localparam int TABLE_ADDR_W = $clog2(PERCEPTRON_TABLE_NUM_ENTRIES);
    localparam int BIAS_ADDR_W  = $clog2(BIAS_TABLE_NUM_ENTRIES);
    localparam int TABLE_IDX_W  = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;
    localparam int INIT_WRITES  = NUM_TABLES * PERCEPTRON_TABLE_NUM_ENTRIES;
    localparam int INIT_CNT_W   = $clog2(INIT_WRITES + 1);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        DECIDE,
        UPDATE
    } train_state_t;

endpackage

// File: rtl/perceptron_weight_updater.sv
// Combinational saturating +/-1 step for one row of perceptron weights.
module perceptron_weight_updater
    import perceptron_train_controller_pkg::*;
(
    input  logic [PERCEPTRON_NUM_WEIGHTS-1:0][PERCEPTRON_WEIGHT_WIDTH-1:0] weights,
    input  logic [PERCEPTRON_NUM_WEIGHTS-1:0]                              history,
    input  logic                                                           taken,
    output logic [PERCEPTRON_NUM_WEIGHTS-1:0][PERCEPTRON_WEIGHT_WIDTH-1:0] new_weights
);

    localparam int WW = PERCEPTRON_WEIGHT_WIDTH;
    localparam logic [WW-1:0] W_MAX = {1'b0, {(WW-1){1'b1}}};
    localparam logic [WW-1:0] W_MIN = {1'b1, {(WW-1){1'b0}}};

    always_comb begin
        new_weights = weights;
        for (int j = 0; j < PERCEPTRON_NUM_WEIGHTS; j++) begin
            // history bit agreeing with the outcome means x*t = +1
            if (history[j] == taken) begin
                if (weights[j] != W_MAX) new_weights[j] = weights[j] + 1'b1;
            end else begin
                if (weights[j] != W_MIN) new_weights[j] = weights[j] - 1'b1;
            end
        end
    end

endmodule

// File: rtl/perceptron_train_controller.sv
// Owns the perceptron weight/bias table write ports: zero sweep after reset,
// then serialised saturating training updates, one table per cycle.
//
// state  | meaning
// INIT   | zero sweep of every table row and bias entry
// IDLE   | ready for a training request
// DECIDE | evaluate mispredict / low-confidence, no writes
// UPDATE | write table k (bias alongside k=0)
module perceptron_train_controller
    import perceptron_train_controller_pkg::*;
#(
    parameter int TRAIN_THRESHOLD = perceptron_train_controller_pkg::TRAIN_THRESHOLD,
    parameter int SUM_WIDTH       = perceptron_train_controller_pkg::SUM_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   train_valid,
    output logic                                   train_ready,
    input  logic                                   train_taken,
    input  logic                                   train_pred_taken,
    input  logic signed [SUM_WIDTH-1:0]            train_sum,
    input  logic [NUM_TABLES-1:0][TABLE_ADDR_W-1:0] train_addrs,
    input  logic [BIAS_ADDR_W-1:0]                 train_bias_addr,
    input  logic [NUM_TABLES-1:0][PERCEPTRON_NUM_WEIGHTS-1:0] train_history,
    input  logic [NUM_TABLES-1:0][PERCEPTRON_NUM_WEIGHTS-1:0][PERCEPTRON_WEIGHT_WIDTH-1:0] train_weights,
    input  logic [BIAS_WEIGHT_WIDTH-1:0]           train_bias_weight,
    output logic                                   write_enable,
    output logic [TABLE_IDX_W-1:0]                 write_table_idx,
    output logic [TABLE_ADDR_W-1:0]                write_addr,
    output logic [PERCEPTRON_NUM_WEIGHTS-1:0][PERCEPTRON_WEIGHT_WIDTH-1:0] write_data,
    output logic                                   bias_write_enable,
    output logic [BIAS_ADDR_W-1:0]                 bias_write_addr,
    output logic [BIAS_WEIGHT_WIDTH-1:0]           bias_write_data,
    output logic                                   init_done,
    output logic                                   busy
);

    localparam int SW1 = SUM_WIDTH + 1;
    localparam int BW  = BIAS_WEIGHT_WIDTH;
    localparam logic [SW1-1:0]         THETA_MAG    = SW1'(TRAIN_THRESHOLD);
    localparam logic [INIT_CNT_W-1:0]  INIT_CNT_END = INIT_CNT_W'(INIT_WRITES);
    localparam logic [INIT_CNT_W-1:0]  BIAS_CNT_END = INIT_CNT_W'(BIAS_TABLE_NUM_ENTRIES);
    localparam logic [TABLE_IDX_W-1:0] LAST_K       = TABLE_IDX_W'(NUM_TABLES - 1);
    localparam logic [BW-1:0]          BIAS_MAX     = {1'b0, {(BW-1){1'b1}}};
    localparam logic [BW-1:0]          BIAS_MIN     = {1'b1, {(BW-1){1'b0}}};

    if (BIAS_TABLE_NUM_ENTRIES > INIT_WRITES) begin : g_bias_too_large
        $error("bias table larger than the perceptron zero sweep");
    end

    train_state_t state, state_nx;
    logic [INIT_CNT_W-1:0]  init_cnt, init_cnt_nx;
    logic [TABLE_IDX_W-1:0] upd_k, upd_k_nx, row_sel;
    logic                   capture;

    logic                                   cap_taken, cap_pred;
    logic signed [SUM_WIDTH-1:0]            cap_sum;
    logic [NUM_TABLES-1:0][TABLE_ADDR_W-1:0] cap_addrs;
    logic [BIAS_ADDR_W-1:0]                 cap_bias_addr;
    logic [NUM_TABLES-1:0][PERCEPTRON_NUM_WEIGHTS-1:0] cap_history;
    logic [NUM_TABLES-1:0][PERCEPTRON_NUM_WEIGHTS-1:0][PERCEPTRON_WEIGHT_WIDTH-1:0] cap_weights;
    logic [BW-1:0]                          cap_bias;

    logic                   we_nx, bwe_nx, ready_nx, busy_nx, init_done_nx;
    logic [TABLE_IDX_W-1:0] idx_nx;
    logic [TABLE_ADDR_W-1:0] addr_nx;
    logic [PERCEPTRON_NUM_WEIGHTS-1:0][PERCEPTRON_WEIGHT_WIDTH-1:0] data_nx, upd_row;
    logic [BIAS_ADDR_W-1:0] baddr_nx;
    logic [BW-1:0]          bdata_nx, bias_next;

    logic signed [SW1-1:0]  sum_ext;
    logic [SW1-1:0]         sum_mag;
    logic                   do_train;

    // one extra bit keeps |most-negative| exact
    assign sum_ext  = {cap_sum[SUM_WIDTH-1], cap_sum};
    assign sum_mag  = sum_ext[SUM_WIDTH] ? (~sum_ext + 1'b1) : sum_ext;
    assign do_train = (cap_taken != cap_pred) || (sum_mag <= THETA_MAG);

    assign row_sel = (state == UPDATE) ? upd_k + 1'b1 : '0;

    perceptron_weight_updater u_updater (
        .weights     (cap_weights[row_sel]),
        .history     (cap_history[row_sel]),
        .taken       (cap_taken),
        .new_weights (upd_row)
    );

    always_comb begin
        bias_next = cap_bias;
        if (cap_taken) begin
            if (cap_bias != BIAS_MAX) bias_next = cap_bias + 1'b1;
        end else begin
            if (cap_bias != BIAS_MIN) bias_next = cap_bias - 1'b1;
        end
    end

    // Output registers are loaded with the action of the state being entered,
    // so every write is registered and reset holds all enables low.
    always_comb begin
        state_nx     = state;
        init_cnt_nx  = init_cnt;
        upd_k_nx     = upd_k;
        capture      = 1'b0;
        we_nx        = 1'b0;
        idx_nx       = write_table_idx;
        addr_nx      = write_addr;
        data_nx      = write_data;
        bwe_nx       = 1'b0;
        baddr_nx     = bias_write_addr;
        bdata_nx     = bias_write_data;
        ready_nx     = 1'b0;
        busy_nx      = 1'b1;
        init_done_nx = init_done;
        unique case (state)
            INIT: begin
                if (init_cnt == INIT_CNT_END) begin
                    state_nx     = IDLE;
                    ready_nx     = 1'b1;
                    busy_nx      = 1'b0;
                    init_done_nx = 1'b1;
                end else begin
                    we_nx   = 1'b1;
                    idx_nx  = TABLE_IDX_W'(32'(init_cnt) / PERCEPTRON_TABLE_NUM_ENTRIES);
                    addr_nx = TABLE_ADDR_W'(32'(init_cnt) % PERCEPTRON_TABLE_NUM_ENTRIES);
                    data_nx = '0;
                    if (init_cnt < BIAS_CNT_END) begin
                        bwe_nx   = 1'b1;
                        baddr_nx = BIAS_ADDR_W'(init_cnt);
                        bdata_nx = '0;
                    end
                    init_cnt_nx = init_cnt + 1'b1;
                end
            end
            IDLE: begin
                ready_nx = 1'b1;
                busy_nx  = 1'b0;
                if (train_valid && train_ready) begin
                    capture  = 1'b1;
                    state_nx = DECIDE;
                    ready_nx = 1'b0;
                    busy_nx  = 1'b1;
                end
            end
            DECIDE: begin
                if (do_train) begin
                    state_nx = UPDATE;
                    upd_k_nx = '0;
                    we_nx    = 1'b1;
                    idx_nx   = row_sel;
                    addr_nx  = cap_addrs[row_sel];
                    data_nx  = upd_row;
                    bwe_nx   = 1'b1;
                    baddr_nx = cap_bias_addr;
                    bdata_nx = bias_next;
                end else begin
                    state_nx = IDLE;
                    ready_nx = 1'b1;
                    busy_nx  = 1'b0;
                end
            end
            UPDATE: begin
                if (upd_k == LAST_K) begin
                    state_nx = IDLE;
                    ready_nx = 1'b1;
                    busy_nx  = 1'b0;
                end else begin
                    upd_k_nx = row_sel;
                    we_nx    = 1'b1;
                    idx_nx   = row_sel;
                    addr_nx  = cap_addrs[row_sel];
                    data_nx  = upd_row;
                end
            end
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= INIT;
            init_cnt          <= '0;
            upd_k             <= '0;
            write_enable      <= 1'b0;
            write_table_idx   <= '0;
            write_addr        <= '0;
            write_data        <= '0;
            bias_write_enable <= 1'b0;
            bias_write_addr   <= '0;
            bias_write_data   <= '0;
            train_ready       <= 1'b0;
            busy              <= 1'b1;
            init_done         <= 1'b0;
        end else begin
            state             <= state_nx;
            init_cnt          <= init_cnt_nx;
            upd_k             <= upd_k_nx;
            write_enable      <= we_nx;
            write_table_idx   <= idx_nx;
            write_addr        <= addr_nx;
            write_data        <= data_nx;
            bias_write_enable <= bwe_nx;
            bias_write_addr   <= baddr_nx;
            bias_write_data   <= bdata_nx;
            train_ready       <= ready_nx;
            busy              <= busy_nx;
            init_done         <= init_done_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_taken     <= 1'b0;
            cap_pred      <= 1'b0;
            cap_sum       <= '0;
            cap_addrs     <= '0;
            cap_bias_addr <= '0;
            cap_history   <= '0;
            cap_weights   <= '0;
            cap_bias      <= '0;
        end else if (capture) begin
            cap_taken     <= train_taken;
            cap_pred      <= train_pred_taken;
            cap_sum       <= train_sum;
            cap_addrs     <= train_addrs;
            cap_bias_addr <= train_bias_addr;
            cap_history   <= train_history;
            cap_weights   <= train_weights;
            cap_bias      <= train_bias_weight;
        end
    end

endmodule

// File: tb/tb_perceptron_train_controller.sv
// Self-checking bench: zero sweep, training decisions, saturation, back-to-back
// requests and reset abort, against a plain-arithmetic reference model.
module tb_perceptron_train_controller;
    import perceptron_train_controller_pkg::*;

    localparam int THETA = 30;
    localparam int SW    = 16;
    localparam int NT    = 4;
    localparam int NE    = 256;
    localparam int NW    = 8;
    localparam int NB    = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                  train_valid = 1'b0;
    logic                  train_ready;
    logic                  train_taken = 1'b0;
    logic                  train_pred_taken = 1'b0;
    logic signed [SW-1:0]  train_sum = '0;
    logic [NT-1:0][7:0]    train_addrs = '0;
    logic [9:0]            train_bias_addr = '0;
    logic [NT-1:0][NW-1:0] train_history = '0;
    logic [NT-1:0][NW-1:0][7:0] train_weights = '0;
    logic [7:0]            train_bias_weight = '0;
    logic                  write_enable;
    logic [1:0]            write_table_idx;
    logic [7:0]            write_addr;
    logic [NW-1:0][7:0]    write_data;
    logic                  bias_write_enable;
    logic [9:0]            bias_write_addr;
    logic [7:0]            bias_write_data;
    logic                  init_done;
    logic                  busy;

    perceptron_train_controller #(.TRAIN_THRESHOLD(THETA), .SUM_WIDTH(SW)) dut (
        .clk               (clk),
        .rst               (rst),
        .train_valid       (train_valid),
        .train_ready       (train_ready),
        .train_taken       (train_taken),
        .train_pred_taken  (train_pred_taken),
        .train_sum         (train_sum),
        .train_addrs       (train_addrs),
        .train_bias_addr   (train_bias_addr),
        .train_history     (train_history),
        .train_weights     (train_weights),
        .train_bias_weight (train_bias_weight),
        .write_enable      (write_enable),
        .write_table_idx   (write_table_idx),
        .write_addr        (write_addr),
        .write_data        (write_data),
        .bias_write_enable (bias_write_enable),
        .bias_write_addr   (bias_write_addr),
        .bias_write_data   (bias_write_data),
        .init_done         (init_done),
        .busy              (busy)
    );

    typedef struct {
        logic                  taken;
        logic                  pred;
        logic signed [SW-1:0]  sum;
        logic [NT-1:0][7:0]    addrs;
        logic [9:0]            bias_addr;
        logic [NT-1:0][NW-1:0] hist;
        logic [NT-1:0][NW-1:0][7:0] w;
        logic signed [7:0]     bias;
    } req_t;

    int n_cmp = 0;
    int n_err = 0;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required summary before limit");
        $fatal(1, "watchdog");
    end

    function automatic int clamp8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic bit model_train(input req_t r);
        int s;
        int a;
        s = r.sum;
        a = (s < 0) ? -s : s;
        return (r.taken != r.pred) || (a <= THETA);
    endfunction

    function automatic req_t random_req();
        req_t r;
        int s;
        r.taken = 1'($urandom_range(0, 1));
        r.pred  = (($urandom_range(0, 2)) == 0) ? ~r.taken : r.taken;
        case ($urandom_range(0, 3))
            0: s = $urandom_range(0, 80) - 40;
            1: s = $urandom_range(0, 65535) - 32768;
            2: s = ($urandom_range(0, 1) == 1) ? 31 : -31;
            default: s = ($urandom_range(0, 1) == 1) ? 30 : -30;
        endcase
        r.sum       = SW'(s);
        r.bias_addr = 10'($urandom_range(0, NB - 1));
        for (int t = 0; t < NT; t++) begin
            r.addrs[t] = 8'($urandom_range(0, NE - 1));
            r.hist[t]  = 8'($urandom_range(0, 255));
            for (int j = 0; j < NW; j++) begin
                case ($urandom_range(0, 3))
                    0: r.w[t][j] = 8'h7f;
                    1: r.w[t][j] = 8'h80;
                    default: r.w[t][j] = 8'($urandom_range(0, 255));
                endcase
            end
        end
        r.bias = 8'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic drive_req(input req_t r);
        train_taken       = r.taken;
        train_pred_taken  = r.pred;
        train_sum         = r.sum;
        train_addrs       = r.addrs;
        train_bias_addr   = r.bias_addr;
        train_history     = r.hist;
        train_weights     = r.w;
        train_bias_weight = r.bias;
    endtask

    // Entered at a negedge. Issues r, then checks every cycle of its response.
    task automatic run_request(input string name, input req_t r, input bit hold, input req_t nxt);
        bit tr;
        int waited;
        logic [NW-1:0][7:0] erow;
        logic [7:0] ebias;
        tr = model_train(r);
        drive_req(r);
        train_valid = 1'b1;
        waited = 0;
        while (train_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (train_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_wait: train_ready=%b required 1", name, train_ready);
            train_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (hold) drive_req(nxt);
        else train_valid = 1'b0;
        n_cmp++;
        if ({write_enable, bias_write_enable, train_ready, busy} !== 4'b0001) begin
            n_err++;
            $display("FAIL %s decide: we=%b bwe=%b ready=%b busy=%b required 0 0 0 1",
                     name, write_enable, bias_write_enable, train_ready, busy);
        end
        if (tr) begin
            for (int k = 0; k < NT; k++) begin
                @(negedge clk);
                for (int j = 0; j < NW; j++)
                    erow[j] = 8'(clamp8(int'($signed(r.w[k][j])) + ((r.hist[k][j] == r.taken) ? 1 : -1)));
                n_cmp++;
                if (write_enable !== 1'b1 || write_table_idx !== 2'(k) || write_addr !== r.addrs[k]) begin
                    n_err++;
                    $display("FAIL %s k%0d port: we=%b idx=%0d addr=%0d required 1 %0d %0d",
                             name, k, write_enable, write_table_idx, write_addr, k, r.addrs[k]);
                end
                n_cmp++;
                if (write_data !== erow) begin
                    n_err++;
                    $display("FAIL %s k%0d data: got %h required %h", name, k, write_data, erow);
                end
                n_cmp++;
                if (bias_write_enable !== (k == 0) || train_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s k%0d bias_we/ready: bwe=%b ready=%b required %b 0",
                             name, k, bias_write_enable, train_ready, k == 0);
                end
                if (k == 0) begin
                    ebias = 8'(clamp8(int'(r.bias) + (r.taken ? 1 : -1)));
                    n_cmp++;
                    if (bias_write_addr !== r.bias_addr || bias_write_data !== ebias) begin
                        n_err++;
                        $display("FAIL %s bias: addr=%0d data=%h required %0d %h",
                                 name, bias_write_addr, bias_write_data, r.bias_addr, ebias);
                    end
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({write_enable, bias_write_enable, train_ready, busy} !== 4'b0010) begin
            n_err++;
            $display("FAIL %s done(train=%0b): we=%b bwe=%b ready=%b busy=%b required 0 0 1 0",
                     name, tr, write_enable, bias_write_enable, train_ready, busy);
        end
    endtask

    // Entered at a negedge with rst low; releases it and follows the sweep.
    task automatic check_sweep(input string name);
        int c = 0;
        int gaps = 0;
        int cyc = 0;
        bit done = 1'b0;
        rst = 1'b1;
        while (!done && cyc < 1200) begin
            @(negedge clk);
            cyc++;
            if (init_done === 1'b1) begin
                done = 1'b1;
            end else begin
                n_cmp++;
                if (train_ready !== 1'b0 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s init_status c%0d: ready=%b busy=%b required 0 1", name, c, train_ready, busy);
                end
                if (write_enable === 1'b1) begin
                    n_cmp++;
                    if (write_table_idx !== 2'(c / NE) || write_addr !== 8'(c % NE) || write_data !== '0) begin
                        n_err++;
                        $display("FAIL %s init_write c%0d: idx=%0d addr=%0d data=%h required %0d %0d 0",
                                 name, c, write_table_idx, write_addr, write_data, c / NE, c % NE);
                    end
                    n_cmp++;
                    if (bias_write_enable !== (c < NB) ||
                        (c < NB && (bias_write_addr !== 10'(c) || bias_write_data !== 8'h00))) begin
                        n_err++;
                        $display("FAIL %s init_bias c%0d: bwe=%b addr=%0d data=%h required %b %0d 0",
                                 name, c, bias_write_enable, bias_write_addr, bias_write_data, c < NB, c);
                    end
                    c++;
                end else begin
                    gaps++;
                end
            end
        end
        n_cmp++;
        if (!done || c != NE * NT || gaps != 0) begin
            n_err++;
            $display("FAIL %s sweep_len: done=%0b writes=%0d idle=%0d required 1 %0d 0", name, done, c, gaps, NE * NT);
        end
        n_cmp++;
        if ({write_enable, bias_write_enable, train_ready, busy} !== 4'b0010) begin
            n_err++;
            $display("FAIL %s after_sweep: we=%b bwe=%b ready=%b busy=%b required 0 0 1 0",
                     name, write_enable, bias_write_enable, train_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        train_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({write_enable, bias_write_enable, init_done, train_ready, busy} !== 5'b00001) begin
            n_err++;
            $display("FAIL reset_ctrl: we=%b bwe=%b init_done=%b ready=%b busy=%b required 0 0 0 0 1",
                     write_enable, bias_write_enable, init_done, train_ready, busy);
        end
        n_cmp++;
        if (write_addr !== '0 || write_table_idx !== '0 || write_data !== '0 ||
            bias_write_addr !== '0 || bias_write_data !== '0) begin
            n_err++;
            $display("FAIL reset_data: idx=%0d addr=%0d data=%h baddr=%0d bdata=%h required all 0",
                     write_table_idx, write_addr, write_data, bias_write_addr, bias_write_data);
        end
        check_sweep("reset_sweep");
    endtask

    task automatic test_mispredict();
        req_t r;
        r = random_req();
        r.taken = 1'b1;
        r.pred  = 1'b0;
        r.sum   = -16'sd5;
        r.bias  = 8'($urandom_range(0, 100));
        for (int t = 0; t < NT; t++) begin
            r.hist[t] = '1;
            for (int j = 0; j < NW; j++) r.w[t][j] = 8'd3;
        end
        run_request("mispredict", r, 1'b0, r);
    endtask

    task automatic test_threshold();
        req_t r;
        int sums[4] = '{31, 30, -30, -31};
        r = random_req();
        r.taken = 1'b1;
        r.pred  = 1'b1;
        foreach (sums[i]) begin
            r.sum = SW'(sums[i]);
            run_request($sformatf("threshold_%0d", sums[i]), r, 1'b0, r);
        end
    endtask

    task automatic test_saturation();
        req_t r;
        r = random_req();
        r.taken = 1'b1;
        r.pred  = 1'b1;
        r.sum   = '0;
        r.bias  = 8'sd127;
        for (int t = 0; t < NT; t++)
            for (int j = 0; j < NW; j++) begin
                r.hist[t][j] = 1'(j % 2);
                r.w[t][j]    = (j % 2 == 1) ? 8'h7f : 8'h80;
            end
        run_request("sat_up", r, 1'b0, r);
        r.taken = 1'b0;
        r.pred  = 1'b0;
        r.bias  = -8'sd128;
        for (int t = 0; t < NT; t++)
            for (int j = 0; j < NW; j++)
                r.w[t][j] = (j % 2 == 1) ? 8'h80 : 8'h7f;
        run_request("sat_down", r, 1'b0, r);
    endtask

    task automatic test_most_negative();
        req_t r;
        r = random_req();
        r.sum   = 16'sh8000;
        r.taken = 1'b0;
        r.pred  = 1'b0;
        run_request("most_neg_nt", r, 1'b0, r);
        r.taken = 1'b1;
        r.pred  = 1'b1;
        run_request("most_neg_t", r, 1'b0, r);
    endtask

    task automatic test_random();
        req_t r;
        for (int i = 0; i < 30; i++) begin
            r = random_req();
            run_request($sformatf("random_%0d", i), r, 1'b0, r);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        req_t a;
        req_t b;
        a = random_req();
        b = random_req();
        a.taken = 1'b1;
        a.pred  = 1'b0;
        b.taken = 1'b0;
        b.pred  = 1'b1;
        run_request("b2b_first", a, 1'b1, b);
        run_request("b2b_second", b, 1'b0, b);
    endtask

    task automatic test_reset_mid_update();
        req_t r;
        int waited = 0;
        r = random_req();
        r.taken = 1'b1;
        r.pred  = 1'b0;
        drive_req(r);
        train_valid = 1'b1;
        while (train_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        @(negedge clk);
        train_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (write_enable !== 1'b1 || write_table_idx !== 2'd1) begin
            n_err++;
            $display("FAIL rst_mid_k1: we=%b idx=%0d required 1 1", write_enable, write_table_idx);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({write_enable, bias_write_enable, init_done, train_ready, busy} !== 5'b00001) begin
            n_err++;
            $display("FAIL rst_mid_abort: we=%b bwe=%b init_done=%b ready=%b busy=%b required 0 0 0 0 1",
                     write_enable, bias_write_enable, init_done, train_ready, busy);
        end
        @(negedge clk);
        check_sweep("rst_mid_sweep");
    endtask

    initial begin
        test_reset();
        test_mispredict();
        test_threshold();
        test_saturation();
        test_most_negative();
        test_random();
        test_back_to_back();
        test_reset_mid_update();
        test_mispredict();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
